// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl
//   Round sequencer for the two-player reaction-time game. A start pulse runs
//   one round: a blink phase, then a dark phase of random length, then live
//   reaction timing. The round ends on a winner-time display or a cheat
//   display. Both players' thermometer scores and the HEX source select are
//   also kept here.
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   i_ms_tick        1-clk pulse once per ms
//   i_start          1-clk pulse: begin a new round
//   i_p1_press       player 1 button level, 1 = pressed
//   i_p2_press       player 2 button level, 1 = pressed
//   i_rnd_value      free-running LFSR value, seeds the dark-phase length
//   o_disp_sel       00 blink, 01 fill digit, 10 live react_ms, 11 winner_time
//   o_fill_digit     digit shown on every HEX digit when o_disp_sel = 01
//   o_react_ms       live reaction timer, ms
//   o_winner_time    reaction time latched at the end of the last round
//   o_win1, o_win2   thermometer scores, bit 0 fills first
//   o_match_over     either score is all-ones
module reaction_round_ctrl #(
  parameter int BLINK_MS    = 3000,
  parameter int MIN_WAIT_MS = 1000,
  parameter int RAND_MASK   = 4095,
  parameter int TIMEOUT_MS  = 9999,
  parameter int SCORE_W     = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_ms_tick,
  input  logic               i_start,
  input  logic               i_p1_press,
  input  logic               i_p2_press,
  input  logic [13:0]        i_rnd_value,
  output logic [1:0]         o_disp_sel,
  output logic [3:0]         o_fill_digit,
  output logic [19:0]        o_react_ms,
  output logic [19:0]        o_winner_time,
  output logic [SCORE_W-1:0] o_win1,
  output logic [SCORE_W-1:0] o_win2,
  output logic               o_match_over
);

  localparam logic [19:0] LP_BLINK   = 20'(BLINK_MS);
  localparam logic [19:0] LP_MINWAIT = 20'(MIN_WAIT_MS);
  localparam logic [13:0] LP_MASK    = 14'(RAND_MASK);
  localparam logic [19:0] LP_TIMEOUT = 20'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BLINK  = 3'd1,
    S_DARK   = 3'd2,
    S_TIMING = 3'd3,
    S_WIN    = 3'd4,
    S_CHEAT  = 3'd5
  } state_t;

  state_t               r_state;
  logic [19:0]          r_phase_ms;
  logic [19:0]          r_wait_ms;
  logic [1:0]           r_disp_sel;
  logic [3:0]           r_fill_digit;
  logic [19:0]          r_react_ms;
  logic [19:0]          r_winner_time;
  logic [SCORE_W-1:0]   r_win1;
  logic [SCORE_W-1:0]   r_win2;
  logic                 r_match_over;

  logic [19:0]          w_wait_ms;
  logic                 w_sc1;
  logic                 w_sc2;
  logic                 w_clr;
  logic [SCORE_W-1:0]   w_win1_nxt;
  logic [SCORE_W-1:0]   w_win2_nxt;

  assign w_wait_ms = LP_MINWAIT + {6'd0, i_rnd_value & LP_MASK};

  // Score strobes mirror the FSM branches below: start always takes priority,
  // a lone press in DARK credits the opponent, a lone press in TIMING credits
  // the presser.
  assign w_sc1 = !i_start &&
                 (((r_state == S_DARK)   &&  i_p2_press && !i_p1_press) ||
                  ((r_state == S_TIMING) &&  i_p1_press && !i_p2_press));
  assign w_sc2 = !i_start &&
                 (((r_state == S_DARK)   &&  i_p1_press && !i_p2_press) ||
                  ((r_state == S_TIMING) &&  i_p2_press && !i_p1_press));
  assign w_clr = i_start && r_match_over &&
                 ((r_state == S_WIN) || (r_state == S_CHEAT));

  // Shift-in-a-one saturates naturally once the register is all-ones.
  assign w_win1_nxt = w_clr ? '0 : (w_sc1 ? {r_win1[SCORE_W-2:0], 1'b1} : r_win1);
  assign w_win2_nxt = w_clr ? '0 : (w_sc2 ? {r_win2[SCORE_W-2:0], 1'b1} : r_win2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win1       <= '0;
      r_win2       <= '0;
      r_match_over <= 1'b0;
    end else begin
      r_win1       <= w_win1_nxt;
      r_win2       <= w_win2_nxt;
      r_match_over <= (&w_win1_nxt) | (&w_win2_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_phase_ms    <= '0;
      r_wait_ms     <= '0;
      r_disp_sel    <= 2'b00;
      r_fill_digit  <= 4'd0;
      r_react_ms    <= '0;
      r_winner_time <= '0;
    end else begin
      // Default: count ms in the current phase; every transition clears it.
      r_phase_ms <= r_phase_ms + {19'd0, i_ms_tick};
      case (r_state)
        S_IDLE, S_WIN, S_CHEAT: begin
          if (i_start) begin
            r_state    <= S_BLINK;
            r_phase_ms <= '0;
            r_wait_ms  <= w_wait_ms;
            r_disp_sel <= 2'b00;
          end
        end
        S_BLINK: begin
          if (i_start) begin
            r_state    <= S_BLINK;
            r_phase_ms <= '0;
            r_wait_ms  <= w_wait_ms;
          end else if (r_phase_ms == LP_BLINK) begin
            r_state      <= S_DARK;
            r_phase_ms   <= '0;
            r_disp_sel   <= 2'b01;
            r_fill_digit <= 4'hF;
          end
        end
        S_DARK: begin
          if (i_start) begin
            r_state    <= S_BLINK;
            r_phase_ms <= '0;
            r_wait_ms  <= w_wait_ms;
            r_disp_sel <= 2'b00;
          end else if (i_p1_press || i_p2_press) begin
            // Jumped the gun: the fill digit names the cheater (8 = both).
            r_state      <= S_CHEAT;
            r_phase_ms   <= '0;
            r_fill_digit <= (i_p1_press && i_p2_press) ? 4'd8 :
                            (i_p1_press ? 4'd1 : 4'd2);
          end else if (r_phase_ms == r_wait_ms) begin
            r_state    <= S_TIMING;
            r_phase_ms <= '0;
            r_react_ms <= '0;
            r_disp_sel <= 2'b10;
          end
        end
        S_TIMING: begin
          if (i_start) begin
            r_state    <= S_BLINK;
            r_phase_ms <= '0;
            r_wait_ms  <= w_wait_ms;
            r_disp_sel <= 2'b00;
          end else if (i_p1_press && i_p2_press) begin
            r_state      <= S_CHEAT;
            r_phase_ms   <= '0;
            r_disp_sel   <= 2'b01;
            r_fill_digit <= 4'd8;
          end else if (i_p1_press || i_p2_press) begin
            r_state       <= S_WIN;
            r_phase_ms    <= '0;
            r_disp_sel    <= 2'b11;
            r_winner_time <= r_react_ms;
          end else if (r_react_ms == LP_TIMEOUT) begin
            r_state       <= S_WIN;
            r_phase_ms    <= '0;
            r_disp_sel    <= 2'b11;
            r_winner_time <= LP_TIMEOUT;
          end else if (i_ms_tick) begin
            r_react_ms <= r_react_ms + 20'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_phase_ms <= '0;
          r_disp_sel <= 2'b00;
        end
      endcase
    end
  end

  assign o_disp_sel    = r_disp_sel;
  assign o_fill_digit  = r_fill_digit;
  assign o_react_ms    = r_react_ms;
  assign o_winner_time = r_winner_time;
  assign o_win1        = r_win1;
  assign o_win2        = r_win2;
  assign o_match_over  = r_match_over;

endmodule
